// File: rtl/spi_msg_framer_pkg.sv
// Shared definitions for the SPI message framer.
// Contents:
//   BYTE_W        width of every byte lane in the framer
//   state_e       framer state encoding
//   DEFAULT_*     default header byte, channel address and payload limit
//   clamp_len     bounds a FIFO fill level to the per-frame payload limit
package spi_msg_framer_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    S_START,
    S_ADDR,
    S_LEN,
    RD_REQ,
    RD_WAIT,
    S_DATA,
    S_CSUM
  } state_e;

  localparam logic [BYTE_W-1:0] DEFAULT_START_BYTE  = 8'hAA;
  localparam logic [BYTE_W-1:0] DEFAULT_ADDR        = 8'h00;
  localparam logic [BYTE_W-1:0] DEFAULT_MAX_PAYLOAD = 8'd255;

  // A backlog longer than the limit is sent as several frames, so the
  // length byte is the smaller of the fill level and the limit.
  function automatic logic [BYTE_W-1:0] clamp_len(input logic [BYTE_W-1:0] fill,
                                                  input logic [BYTE_W-1:0] max_len);
    return (fill > max_len) ? max_len : fill;
  endfunction

endpackage

// File: rtl/spi_msg_framer_if.sv
// Bundles the framer's two byte paths: the read side of the SPI slave FIFO
// and the valid/ready byte stream toward the host transmit mux.
// Signals:
//   have_msg   FIFO not empty
//   len        FIFO used words
//   in_data    FIFO q, valid one cycle after enc_rdreq
//   enc_rdreq  one-cycle read request per byte
//   tx_data    framed byte
//   tx_valid   tx_data is valid
//   tx_ready   sink accepts the byte; transfer on tx_valid & tx_ready
// Modports:
//   master     the framer
//   slave      the FIFO and the tx sink
interface spi_msg_framer_if;
  import spi_msg_framer_pkg::*;

  logic              have_msg;
  logic [BYTE_W-1:0] len;
  logic [BYTE_W-1:0] in_data;
  logic              enc_rdreq;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  have_msg, len, in_data, tx_ready,
    output enc_rdreq, tx_data, tx_valid
  );

  modport slave (
    output have_msg, len, in_data, tx_ready,
    input  enc_rdreq, tx_data, tx_valid
  );

endinterface

// File: rtl/spi_msg_framer.sv
// Drains bytes from an SPI slave FIFO and sends them to the host as framed
// packets: START, ADDR, LEN, payload, CHECKSUM. The checksum is the XOR of
// ADDR, LEN and every payload byte.
// Ports:
//   sys_clk  system clock (FIFO read side and tx side)
//   rst      asynchronous active-high reset; truncates a frame in flight
//   bus      spi_msg_framer_if.master: FIFO read side and tx byte stream
//   busy     high while a frame is in progress
// Parameters:
//   START_BYTE   first byte of every frame
//   ADDR         channel address byte
//   MAX_PAYLOAD  payload bytes per frame, 1..255
module spi_msg_framer
  import spi_msg_framer_pkg::*;
#(
  parameter logic [BYTE_W-1:0] START_BYTE  = DEFAULT_START_BYTE,
  parameter logic [BYTE_W-1:0] ADDR        = DEFAULT_ADDR,
  parameter logic [BYTE_W-1:0] MAX_PAYLOAD = DEFAULT_MAX_PAYLOAD
) (
  input  logic             sys_clk,
  input  logic             rst,
  spi_msg_framer_if.master bus,
  output logic             busy
);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] cnt_q, cnt_d;
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  logic [BYTE_W-1:0] frame_len;
  logic              xfer;

  assign frame_len = clamp_len(bus.len, MAX_PAYLOAD);
  assign xfer      = bus.tx_valid & bus.tx_ready;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      csum_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      hold_q  <= hold_d;
    end
  end

  // cnt_q holds N from the start of the frame until the first payload byte
  // is accepted, so it doubles as the LEN byte. The checksum is seeded with
  // ADDR ^ N at start so that only payload bytes are folded in later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        // len can lag have_msg by a cycle; wait for a non-zero count.
        if (bus.have_msg && (bus.len != '0)) begin
          cnt_d   = frame_len;
          csum_d  = ADDR ^ frame_len;
          state_d = S_START;
        end
      end
      S_START: if (xfer) state_d = S_ADDR;
      S_ADDR:  if (xfer) state_d = S_LEN;
      S_LEN:   if (xfer) state_d = RD_REQ;
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: begin
        hold_d  = bus.in_data;
        csum_d  = csum_q ^ bus.in_data;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (xfer) begin
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? S_CSUM : RD_REQ;
        end
      end
      S_CSUM:  if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the state register only, so tx_ready never reaches
  // tx_data/tx_valid combinationally.
  always_comb begin
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus.enc_rdreq = 1'b0;
    busy          = (state_q != IDLE);
    case (state_q)
      S_START: begin bus.tx_valid = 1'b1; bus.tx_data = START_BYTE; end
      S_ADDR:  begin bus.tx_valid = 1'b1; bus.tx_data = ADDR;       end
      S_LEN:   begin bus.tx_valid = 1'b1; bus.tx_data = cnt_q;      end
      RD_REQ:  bus.enc_rdreq = 1'b1;
      S_DATA:  begin bus.tx_valid = 1'b1; bus.tx_data = hold_q;     end
      S_CSUM:  begin bus.tx_valid = 1'b1; bus.tx_data = csum_q;     end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_msg_framer.sv
// Bench for spi_msg_framer with ADDR=8'h21 and MAX_PAYLOAD=4. A small
// FIFO model feeds the framer and every accepted tx byte is recorded with
// its cycle number.
module tb_spi_msg_framer;

  localparam logic [7:0] ADDR_P = 8'h21;
  localparam logic [7:0] MAX_P  = 8'd4;

  typedef struct {
    int                n_in;
    logic [0:5][7:0]   in_bytes;
    int                n_exp;
    logic [0:15][7:0]  exp_bytes;
    int                exp_reads;
  } vec_t;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  logic busy;
  logic lag     = 1'b0;

  spi_msg_framer_if bus();

  spi_msg_framer #(
    .START_BYTE (8'hAA),
    .ADDR       (ADDR_P),
    .MAX_PAYLOAD(MAX_P)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // FIFO model: the bench writes, the framer reads; q appears one cycle
  // after the read request.
  logic [7:0] fifo_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int fill;

  assign fill         = wr_ptr - rd_ptr;
  assign bus.have_msg = lag | (fill != 0);
  assign bus.len      = lag ? 8'd0 : fill[7:0];

  always @(posedge sys_clk) begin
    if (bus.enc_rdreq) begin
      bus.in_data <= fifo_mem[rd_ptr[7:0]];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  // Records every accepted byte and the cycle it was accepted in.
  logic [7:0] cap_mem [0:255];
  int         cap_cyc [0:255];
  int         cap_cnt = 0;
  int         cyc     = 0;

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (bus.tx_valid && bus.tx_ready) begin
      cap_mem[cap_cnt[7:0]] <= bus.tx_data;
      cap_cyc[cap_cnt[7:0]] <= cyc;
      cap_cnt               <= cap_cnt + 1;
    end
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cap_base = 0;
  int   rd_base  = 0;
  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic mark_bases();
    cap_base = cap_cnt;
    rd_base  = rd_ptr;
  endtask

  task automatic applyStimulus(input int v);
    mark_bases();
    for (int i = 0; i < vecs[v].n_in; i++) push_byte(vecs[v].in_bytes[i]);
  endtask

  // Waits until the framer is idle with the FIFO drained.
  task automatic wait_done(input string tag, input int budget);
    int quiet;
    quiet = 0;
    for (int c = 0; c < budget && quiet < 2; c++) begin
      @(negedge sys_clk);
      if (!busy && fill == 0) quiet++;
      else quiet = 0;
    end
    checkOutput($sformatf("%s done", tag), (quiet >= 2) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_stream(input string tag, input int n_exp,
                              input logic [0:15][7:0] exp, input int exp_reads);
    int k;
    checkOutput($sformatf("%s count", tag), cap_cnt - cap_base, n_exp);
    for (int i = 0; i < n_exp; i++) begin
      k = cap_base + i;
      checkOutput($sformatf("%s byte%0d", tag, i), cap_mem[k[7:0]], exp[i]);
    end
    checkOutput($sformatf("%s reads", tag), rd_ptr - rd_base, exp_reads);
  endtask

  function automatic int cap_gap(input int i);
    int a, b;
    a = cap_base + i;
    b = a + 1;
    return cap_cyc[b[7:0]] - cap_cyc[a[7:0]];
  endfunction

  initial begin
    int found;
    bus.tx_ready = 1'b1;

    vecs[0].n_in = 3; vecs[0].in_bytes = {8'h01, 8'h02, 8'h03, 24'h0};
    vecs[0].n_exp = 7; vecs[0].exp_reads = 3;
    vecs[0].exp_bytes = {8'hAA, 8'h21, 8'h03, 8'h01, 8'h02, 8'h03, 8'h22, 72'h0};

    vecs[1].n_in = 6; vecs[1].in_bytes = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    vecs[1].n_exp = 14; vecs[1].exp_reads = 6;
    vecs[1].exp_bytes = {8'hAA, 8'h21, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13, 8'h25,
                         8'hAA, 8'h21, 8'h02, 8'h14, 8'h15, 8'h22, 16'h0};

    vecs[2].n_in = 1; vecs[2].in_bytes = {8'h5A, 40'h0};
    vecs[2].n_exp = 5; vecs[2].exp_reads = 1;
    vecs[2].exp_bytes = {8'hAA, 8'h21, 8'h01, 8'h5A, 8'h7A, 88'h0};

    vecs[3].n_in = 4; vecs[3].in_bytes = {8'hFF, 8'h00, 8'h80, 8'h7F, 16'h0};
    vecs[3].n_exp = 8; vecs[3].exp_reads = 4;
    vecs[3].exp_bytes = {8'hAA, 8'h21, 8'h04, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'h25, 64'h0};

    vecs[4].n_in = 5; vecs[4].in_bytes = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0};
    vecs[4].n_exp = 13; vecs[4].exp_reads = 5;
    vecs[4].exp_bytes = {8'hAA, 8'h21, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h21,
                         8'hAA, 8'h21, 8'h01, 8'h05, 8'h25, 24'h0};

    // Reset state
    repeat (2) @(negedge sys_clk);
    checkOutput("reset tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    checkOutput("reset enc_rdreq", {31'd0, bus.enc_rdreq}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset tx_data", {24'd0, bus.tx_data}, 32'd0);
    rst = 1'b0;

    // Empty FIFO: nothing may happen
    repeat (10) begin
      @(negedge sys_clk);
      checkOutput("empty outputs", {29'd0, bus.tx_valid, bus.enc_rdreq, busy}, 32'd0);
    end

    for (int v = 0; v < 5; v++) begin
      applyStimulus(v);
      wait_done($sformatf("vec%0d", v), 300);
      check_stream($sformatf("vec%0d", v), vecs[v].n_exp, vecs[v].exp_bytes,
                   vecs[v].exp_reads);
      if (v == 0) begin
        for (int i = 0; i < 6; i++)
          checkOutput($sformatf("vec0 gap%0d", i), cap_gap(i),
                      (i == 2 || i == 3 || i == 4) ? 32'd3 : 32'd1);
      end
      if (v == 1) checkOutput("vec1 idle gap", cap_gap(7), 32'd2);
    end

    // Backpressure while payload byte 02 is presented
    mark_bases();
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    found = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      @(negedge sys_clk);
      if (cap_cnt - cap_base == 4 && bus.tx_valid) found = 1;
    end
    checkOutput("stall reached", found, 32'd1);
    bus.tx_ready = 1'b0;
    checkOutput("stall entry", {22'd0, bus.tx_valid, bus.tx_data, bus.enc_rdreq}, {22'd0, 1'b1, 8'h02, 1'b0});
    repeat (5) begin
      @(negedge sys_clk);
      checkOutput("stall hold", {22'd0, bus.tx_valid, bus.tx_data, bus.enc_rdreq}, {22'd0, 1'b1, 8'h02, 1'b0});
    end
    checkOutput("stall reads", rd_ptr - rd_base, 32'd2);
    bus.tx_ready = 1'b1;
    wait_done("stall", 100);
    check_stream("stall", 7, {8'hAA, 8'h21, 8'h03, 8'h01, 8'h02, 8'h03, 8'h22, 72'h0}, 3);

    // have_msg high with len stuck at 0
    mark_bases();
    lag = 1'b1;
    push_byte(8'h77);
    repeat (4) begin
      @(negedge sys_clk);
      checkOutput("lag outputs", {29'd0, bus.tx_valid, bus.enc_rdreq, busy}, 32'd0);
    end
    checkOutput("lag reads", rd_ptr - rd_base, 32'd0);
    lag = 1'b0;
    @(negedge sys_clk);
    checkOutput("lag start", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, 8'hAA});
    wait_done("lag", 100);
    check_stream("lag", 5, {8'hAA, 8'h21, 8'h01, 8'h77, 8'h57, 88'h0}, 1);

    // Reset after the second of five payload bytes
    mark_bases();
    push_byte(8'h10); push_byte(8'h11); push_byte(8'h12); push_byte(8'h13); push_byte(8'h14);
    found = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      @(negedge sys_clk);
      if (cap_cnt - cap_base == 5) found = 1;
    end
    checkOutput("rst reached", found, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst outputs", {29'd0, bus.tx_valid, bus.enc_rdreq, busy}, 32'd0);
    @(negedge sys_clk);
    checkOutput("rst reads", rd_ptr - rd_base, 32'd2);
    rst = 1'b0;
    mark_bases();
    wait_done("after rst", 100);
    check_stream("after rst", 7, {8'hAA, 8'h21, 8'h03, 8'h12, 8'h13, 8'h14, 8'h37, 72'h0}, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
